// File: rtl/icc_branch_unit_pkg.sv
// Shared SPARC integer-unit definitions: Bicc condition codes, icc flag bit
// positions and the branch delay-slot sequencer states.
package icc_branch_unit_pkg;

  localparam logic [3:0] BN   = 4'b0000;
  localparam logic [3:0] BE   = 4'b0001;
  localparam logic [3:0] BLE  = 4'b0010;
  localparam logic [3:0] BL   = 4'b0011;
  localparam logic [3:0] BLEU = 4'b0100;
  localparam logic [3:0] BCS  = 4'b0101;
  localparam logic [3:0] BNEG = 4'b0110;
  localparam logic [3:0] BVS  = 4'b0111;
  localparam logic [3:0] BA   = 4'b1000;
  localparam logic [3:0] BNE  = 4'b1001;
  localparam logic [3:0] BG   = 4'b1010;
  localparam logic [3:0] BGE  = 4'b1011;
  localparam logic [3:0] BGU  = 4'b1100;
  localparam logic [3:0] BCC  = 4'b1101;
  localparam logic [3:0] BPOS = 4'b1110;
  localparam logic [3:0] BVC  = 4'b1111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DSLOT = 2'd1,
    ANNUL = 2'd2
  } br_state_e;

endpackage

// File: rtl/icc_branch_unit_cond_eval.sv
// Combinational Bicc condition evaluator over a {N,Z,V,C} flag vector.
module icc_cond_eval
  import icc_branch_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] f,
  output logic       taken
);

  logic n, z, v, c;

  always_comb begin
    n = f[FLAG_N];
    z = f[FLAG_Z];
    v = f[FLAG_V];
    c = f[FLAG_C];
    taken = 1'b0;
    case (cond)
      BN:      taken = 1'b0;
      BE:      taken = z;
      BLE:     taken = z | (n ^ v);
      BL:      taken = n ^ v;
      BLEU:    taken = c | z;
      BCS:     taken = c;
      BNEG:    taken = n;
      BVS:     taken = v;
      BA:      taken = 1'b1;
      BNE:     taken = ~z;
      BG:      taken = ~(z | (n ^ v));
      BGE:     taken = ~(n ^ v);
      BGU:     taken = ~(c | z);
      BCC:     taken = ~c;
      BPOS:    taken = ~n;
      BVC:     taken = ~v;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/icc_branch_unit.sv
// Integer condition-code register, Bicc evaluation with icc forwarding,
// delay-slot/annul sequencer and saturating branch statistics.
module icc_branch_unit
  import icc_branch_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       alu_flags,
  input  logic             cc_we,
  input  logic             br_valid,
  input  logic [3:0]       br_cond,
  input  logic             br_annul,
  input  logic             stall,
  output logic [3:0]       icc,
  output logic             alu_cin,
  output logic             br_taken,
  output logic             squash,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] tkn_cnt
);

  br_state_e        state_q, state_d;
  logic [3:0]       icc_q;
  logic             br_taken_q;
  logic [CNT_W-1:0] br_cnt_q, tkn_cnt_q;

  logic       in_annul;
  logic       accept;
  logic       icc_wr;
  logic [3:0] eval_flags;
  logic       cond_true;
  logic       do_annul;

  icc_cond_eval u_cond_eval (
    .cond  (br_cond),
    .f     (eval_flags),
    .taken (cond_true)
  );

  always_comb begin
    in_annul   = (state_q == ANNUL);
    accept     = br_valid & ~stall & ~in_annul;
    icc_wr     = cc_we & ~stall & ~in_annul;
    // A cc-setting op paired with the branch supplies the flags directly.
    eval_flags = (cc_we & br_valid) ? alu_flags : icc_q;
    do_annul   = br_annul & (~cond_true | (br_cond == BA));
  end

  always_comb begin
    state_d = state_q;
    if (!stall) begin
      case (state_q)
        IDLE, DSLOT: begin
          if (accept) state_d = do_annul ? ANNUL : DSLOT;
          else        state_d = IDLE;
        end
        ANNUL:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      icc_q      <= '0;
      br_taken_q <= 1'b0;
      br_cnt_q   <= '0;
      tkn_cnt_q  <= '0;
    end else if (!stall) begin
      state_q    <= state_d;
      br_taken_q <= accept & cond_true;
      if (icc_wr) icc_q <= alu_flags;
      if (accept && br_cnt_q != '1) br_cnt_q <= br_cnt_q + 1'b1;
      if (accept && cond_true && tkn_cnt_q != '1) tkn_cnt_q <= tkn_cnt_q + 1'b1;
    end
  end

  assign icc      = icc_q;
  assign alu_cin  = icc_q[FLAG_C];
  assign br_taken = br_taken_q;
  assign squash   = (state_q == ANNUL);
  assign br_cnt   = br_cnt_q;
  assign tkn_cnt  = tkn_cnt_q;

endmodule

// File: tb/tb_icc_branch_unit.sv
// Directed self-checking bench for icc_branch_unit.
module tb_icc_branch_unit;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic [3:0]       alu_flags;
  logic             cc_we;
  logic             br_valid;
  logic [3:0]       br_cond;
  logic             br_annul;
  logic             stall;
  logic [3:0]       icc;
  logic             alu_cin;
  logic             br_taken;
  logic             squash;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] tkn_cnt;

  int unsigned checks;
  int unsigned errors;
  int unsigned exp_br;
  int unsigned exp_tk;

  icc_branch_unit #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_flags (alu_flags),
    .cc_we     (cc_we),
    .br_valid  (br_valid),
    .br_cond   (br_cond),
    .br_annul  (br_annul),
    .stall     (stall),
    .icc       (icc),
    .alu_cin   (alu_cin),
    .br_taken  (br_taken),
    .squash    (squash),
    .br_cnt    (br_cnt),
    .tkn_cnt   (tkn_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    cc_we = 1'b0; br_valid = 1'b0; br_cond = 4'b0000; br_annul = 1'b0; alu_flags = 4'b0000;
  endtask

  typedef struct {
    logic [3:0] flags;
    logic [3:0] cond;
    logic       exp;
  } cond_vec_t;

  cond_vec_t vecs[11];

  initial begin
    checks = 0; errors = 0;
    vecs[0]  = '{4'b1000, 4'b0011, 1'b1};
    vecs[1]  = '{4'b1010, 4'b0011, 1'b0};
    vecs[2]  = '{4'b1000, 4'b0010, 1'b1};
    vecs[3]  = '{4'b0000, 4'b1010, 1'b1};
    vecs[4]  = '{4'b0001, 4'b1100, 1'b0};
    vecs[5]  = '{4'b0000, 4'b1100, 1'b1};
    vecs[6]  = '{4'b0001, 4'b0101, 1'b1};
    vecs[7]  = '{4'b1000, 4'b1110, 1'b0};
    vecs[8]  = '{4'b0000, 4'b0000, 1'b0};
    vecs[9]  = '{4'b0010, 4'b1111, 1'b0};
    vecs[10] = '{4'b0010, 4'b1011, 1'b0};

    // 1: reset while stalled
    rst_n = 1'b0; stall = 1'b1; idle_inputs();
    step(); step();
    chk("rst_icc", 32'(icc), 32'h0);
    chk("rst_cin", 32'(alu_cin), 32'h0);
    chk("rst_taken", 32'(br_taken), 32'h0);
    chk("rst_squash", 32'(squash), 32'h0);
    chk("rst_brcnt", 32'(br_cnt), 32'h0);
    chk("rst_tkncnt", 32'(tkn_cnt), 32'h0);
    rst_n = 1'b1; stall = 1'b0;
    step();
    chk("rel_icc", 32'(icc), 32'h0);
    chk("rel_cin", 32'(alu_cin), 32'h0);

    // 2: forwarded flags with BVS
    cc_we = 1'b1; alu_flags = 4'b1010; br_valid = 1'b1; br_cond = 4'b0111; br_annul = 1'b0;
    step();
    chk("fwd_taken", 32'(br_taken), 32'h1);
    chk("fwd_icc", 32'(icc), 32'ha);
    chk("fwd_tkncnt", 32'(tkn_cnt), 32'h1);
    chk("fwd_brcnt", 32'(br_cnt), 32'h1);
    chk("fwd_squash", 32'(squash), 32'h0);
    idle_inputs();
    step();
    chk("fwd_taken_drop", 32'(br_taken), 32'h0);

    // 3: BNE,a not taken annuls; squashed slot is inert
    cc_we = 1'b1; alu_flags = 4'b0100;
    step();
    idle_inputs();
    br_valid = 1'b1; br_cond = 4'b1001; br_annul = 1'b1;
    step();
    chk("bne_a_taken", 32'(br_taken), 32'h0);
    chk("bne_a_squash", 32'(squash), 32'h1);
    chk("bne_a_brcnt", 32'(br_cnt), 32'h2);
    br_valid = 1'b1; br_cond = 4'b1000; br_annul = 1'b0; cc_we = 1'b1; alu_flags = 4'b1111;
    step();
    chk("sq_squash_end", 32'(squash), 32'h0);
    chk("sq_taken", 32'(br_taken), 32'h0);
    chk("sq_icc", 32'(icc), 32'h4);
    chk("sq_brcnt", 32'(br_cnt), 32'h2);
    chk("sq_tkncnt", 32'(tkn_cnt), 32'h1);
    idle_inputs();

    // 4: BA,a annuls though taken; BA without a does not
    br_valid = 1'b1; br_cond = 4'b1000; br_annul = 1'b1;
    step();
    chk("ba_a_taken", 32'(br_taken), 32'h1);
    chk("ba_a_squash", 32'(squash), 32'h1);
    idle_inputs();
    step();
    chk("ba_a_squash_end", 32'(squash), 32'h0);
    br_valid = 1'b1; br_cond = 4'b1000; br_annul = 1'b0;
    step();
    chk("ba_taken", 32'(br_taken), 32'h1);
    chk("ba_squash", 32'(squash), 32'h0);
    chk("ba_brcnt", 32'(br_cnt), 32'h4);
    chk("ba_tkncnt", 32'(tkn_cnt), 32'h3);
    idle_inputs();
    step();
    chk("ba_taken_drop", 32'(br_taken), 32'h0);

    // 5: carry to ALU and stall hold
    cc_we = 1'b1; alu_flags = 4'b0001;
    step();
    chk("c_icc", 32'(icc), 32'h1);
    chk("c_cin", 32'(alu_cin), 32'h1);
    stall = 1'b1; alu_flags = 4'b0000; br_valid = 1'b1; br_cond = 4'b1000;
    step(); step();
    chk("stall_icc", 32'(icc), 32'h1);
    chk("stall_cin", 32'(alu_cin), 32'h1);
    chk("stall_brcnt", 32'(br_cnt), 32'h4);
    chk("stall_taken", 32'(br_taken), 32'h0);
    stall = 1'b0; br_valid = 1'b0;
    step();
    chk("unstall_icc", 32'(icc), 32'h0);
    chk("unstall_cin", 32'(alu_cin), 32'h0);
    idle_inputs();

    // condition table sweep on registered icc
    exp_br = 4; exp_tk = 3;
    foreach (vecs[i]) begin
      cc_we = 1'b1; alu_flags = vecs[i].flags;
      step();
      idle_inputs();
      br_valid = 1'b1; br_cond = vecs[i].cond;
      step();
      chk($sformatf("cond_%0d", i), 32'(br_taken), 32'(vecs[i].exp));
      exp_br++;
      if (vecs[i].exp) exp_tk++;
      idle_inputs();
      step();
    end
    chk("sweep_brcnt", 32'(br_cnt), exp_br);
    chk("sweep_tkncnt", 32'(tkn_cnt), exp_tk);

    // 6: saturation via back-to-back BA, then reset during annul
    br_valid = 1'b1; br_cond = 4'b1000; br_annul = 1'b0;
    repeat ((1 << CNT_W) + 3) step();
    chk("sat_brcnt", 32'(br_cnt), 32'hffff);
    chk("sat_tkncnt", 32'(tkn_cnt), 32'hffff);
    br_annul = 1'b1;
    step();
    chk("sat_squash", 32'(squash), 32'h1);
    chk("sat_hold", 32'(br_cnt), 32'hffff);
    idle_inputs();
    rst_n = 1'b0;
    step();
    chk("rst2_squash", 32'(squash), 32'h0);
    chk("rst2_brcnt", 32'(br_cnt), 32'h0);
    chk("rst2_tkncnt", 32'(tkn_cnt), 32'h0);
    chk("rst2_taken", 32'(br_taken), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
